pipeline_run_controller: RTL

Parametrised run/debug controller for the pipeline processor, replacing ad-hoc controller_enable/resume handling with one FSM. It generates per-stage enables, fetch enable and flush masks, and halts cleanly on a HALT instruction or PC breakpoint by draining in-flight instructions. It supports resume, single-step and a saturating active-cycle counter. Sits between the top-level pipeline and the testbench/debug host.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/rise_edge_det.sv | 33 +++
 rtl/pipeline_run_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline run/debug controller:
//   - state_e : 3-bit FSM state encoding (IDLE/RUN/DRAIN/HALTED/STEP)
//   - cause_e : halt cause codes reported on halt_cause
//   - DEF_*   : default parameter values for pipeline_run_controller
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HALTED = 3'd3,
        ST_STEP   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_HALT = 2'd1,
        CAUSE_BP   = 2'd2,
        CAUSE_STEP = 2'd3
    } cause_e;

    localparam int DEF_PC_W     = 8;
    localparam int DEF_STAGES   = 4;
    localparam int DEF_BR_STAGE = 2;
    localparam int DEF_NUM_BP   = 2;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/rise_edge_det.sv
// ----------------------------------------------------------------------------
// rise_edge_det
// Rising-edge detector with a registered history bit. pulse_o is high for the
// single cycle in which sig_i is 1 and its previous sample was 0, so a level
// held high yields exactly one pulse.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (history cleared to 0)
//   sig_i   : level input to watch
//   pulse_o : one-cycle rising-edge pulse
// ----------------------------------------------------------------------------
module rise_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic pulse_o
);

    logic prev_q;

    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign pulse_o = sig_i & ~prev_q;

endmodule

// File: rtl/pipeline_run_controller.sv
// ----------------------------------------------------------------------------
// pipeline_run_controller
// Run/debug controller for the pipeline processor. One FSM produces the fetch
// enable, per-stage enables and flush mask, halts on a HALT instruction or a
// PC breakpoint by draining the in-flight instructions (STAGES-1 cycles), and
// supports resume, single-step and a saturating active-cycle counter.
//
// Build option: define PIPE_BREAKPOINT_EN to enable the PC breakpoint
// comparators. When undefined the bp_addr/bp_valid ports remain but are
// ignored and halt_cause never reports a breakpoint.
//
// Ports:
//   main_clk          : clock, rising edge
//   restart_n         : asynchronous active-low reset
//   controller_enable : level, 0 forces IDLE (highest priority)
//   resume / step_req : levels, rising edges act only in HALTED
//   halt_instr        : decode stage holds a HALT opcode
//   flush_req         : branch taken/mispredict at BR_STAGE
//   pc                : current fetch PC
//   bp_addr/bp_valid  : packed breakpoint addresses and their enables
//   fetch_en/stage_en : fetch and per-stage advance enables
//   flush             : per-stage bubble insert (stages 0..BR_STAGE-1)
//   running/halted    : state is RUN / state is HALTED
//   halt_cause        : 0 none, 1 HALT instr, 2 breakpoint, 3 step done
//   cycle_cnt         : saturating count of RUN/STEP/DRAIN cycles
// ----------------------------------------------------------------------------
module pipeline_run_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W     = DEF_PC_W,
    parameter int STAGES   = DEF_STAGES,
    parameter int BR_STAGE = DEF_BR_STAGE,
    parameter int NUM_BP   = DEF_NUM_BP,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                   main_clk,
    input  logic                   restart_n,
    input  logic                   controller_enable,
    input  logic                   resume,
    input  logic                   step_req,
    input  logic                   halt_instr,
    input  logic                   flush_req,
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_valid,
    output logic                   fetch_en,
    output logic [STAGES-1:0]      stage_en,
    output logic [STAGES-1:0]      flush,
    output logic                   running,
    output logic                   halted,
    output logic [1:0]             halt_cause,
    output logic [CNT_W-1:0]       cycle_cnt
);

    localparam int DRAIN_W = (STAGES > 2) ? $clog2(STAGES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(STAGES - 1);
    localparam logic [STAGES-1:0]  FLUSH_MASK = STAGES'((1 << BR_STAGE) - 1);

    // ------------------------------------------------------------------
    // Edge detection for the debug-host handshakes
    // ------------------------------------------------------------------
    logic resume_pulse;
    logic step_pulse;

    rise_edge_det u_resume_det (
        .clk_i   (main_clk),
        .rst_ni  (restart_n),
        .sig_i   (resume),
        .pulse_o (resume_pulse)
    );

    rise_edge_det u_step_det (
        .clk_i   (main_clk),
        .rst_ni  (restart_n),
        .sig_i   (step_req),
        .pulse_o (step_pulse)
    );

    // ------------------------------------------------------------------
    // Breakpoint comparators
    // ------------------------------------------------------------------
    logic bp_hit;

`ifdef PIPE_BREAKPOINT_EN
    always_comb begin
        bp_hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_valid[i] && (bp_addr[i*PC_W +: PC_W] == pc)) begin
                bp_hit = 1'b1;
            end
        end
    end
`else
    logic unused_bp;
    assign unused_bp = ^{bp_addr, bp_valid, pc};
    assign bp_hit    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    state_e               state_q,  state_d;
    cause_e               cause_q,  cause_d;
    logic [DRAIN_W-1:0]   drain_q,  drain_d;
    logic [STAGES-1:0]    flush_q,  flush_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 active;

    assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_STEP);

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        drain_d = drain_q;
        flush_d = '0;
        cnt_d   = cnt_q;

        if (!controller_enable) begin
            // Disable overrides everything; counter holds, drain is abandoned.
            state_d = ST_IDLE;
            cause_d = CAUSE_NONE;
            drain_d = '0;
        end else begin
            if (active && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (active && flush_req) begin
                flush_d = FLUSH_MASK;
            end

            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    // A HALT seen alongside a flush was fetched down the wrong
                    // path, so it is discarded.
                    if (halt_instr && !flush_req) begin
                        state_d = ST_DRAIN;
                        cause_d = CAUSE_HALT;
                        drain_d = DRAIN_LOAD;
                    end else if (bp_hit) begin
                        state_d = ST_DRAIN;
                        cause_d = CAUSE_BP;
                        drain_d = DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // Counter was loaded with STAGES-1 on entry; the cycle in
                    // which it would reach 0 is the last drain cycle.
                    if (drain_q <= DRAIN_W'(1)) begin
                        state_d = ST_HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
                ST_HALTED: begin
                    if (resume_pulse) begin
                        state_d = ST_RUN;
                        cause_d = CAUSE_NONE;
                    end else if (step_pulse) begin
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    state_d = ST_DRAIN;
                    cause_d = CAUSE_STEP;
                    drain_d = DRAIN_LOAD;
                end
                default: begin
                    state_d = ST_IDLE;
                    cause_d = CAUSE_NONE;
                    drain_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    logic              fetch_en_q;
    logic [STAGES-1:0] stage_en_q;
    logic              running_q;
    logic              halted_q;

    // NOTE: only control state lives in these flops; all of it takes the
    // asynchronous reset so the controller comes up quiescent in IDLE.
    always_ff @(posedge main_clk or negedge restart_n) begin
        if (!restart_n) begin
            state_q    <= ST_IDLE;
            cause_q    <= CAUSE_NONE;
            drain_q    <= '0;
            flush_q    <= '0;
            cnt_q      <= '0;
            fetch_en_q <= 1'b0;
            stage_en_q <= '0;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            drain_q    <= drain_d;
            flush_q    <= flush_d;
            cnt_q      <= cnt_d;
            fetch_en_q <= (state_d == ST_RUN) || (state_d == ST_STEP);
            stage_en_q <= ((state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN))
                          ? {STAGES{1'b1}} : '0;
            running_q  <= (state_d == ST_RUN);
            halted_q   <= (state_d == ST_HALTED);
        end
    end

    assign fetch_en   = fetch_en_q;
    assign stage_en   = stage_en_q;
    assign flush      = flush_q;
    assign running    = running_q;
    assign halted     = halted_q;
    assign halt_cause = cause_q;
    assign cycle_cnt  = cnt_q;

endmodule
